// File: rtl/domain_task_arbiter.sv
// Round-robin arbiter sharing one domain_task crossing channel among N
// clkA-side requesters. Latches the winner's command, issues a one-cycle
// TaskStart, holds the grant until TaskDone and returns a per-requester Done
// pulse. A sticky watchdog flags tasks outstanding for TIMEOUT WAIT cycles.
module domain_task_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic           clkA,
    input  logic           Reset_clkA,
    input  logic [N-1:0]   Req_clkA,
    input  logic [N*W-1:0] Cmd_clkA,
    output logic [N-1:0]   Grant_clkA,
    output logic [N-1:0]   Done_clkA,
    output logic           TaskStart_clkA,
    output logic [W-1:0]   TaskCmd_clkA,
    input  logic           TaskBusy_clkA,
    input  logic           TaskDone_clkA,
    output logic           Timeout_clkA
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } stateT;

    stateT         state;
    logic [IW-1:0] last;
    logic [IW-1:0] grantIdx;
    logic [IW-1:0] selIdx;
    logic          selValid;
    logic [CW-1:0] wdCnt;
    int unsigned   cand;

    // Pick the first requester searching upward from last+1, wrapping at N
    always_comb begin
        selValid = 1'b0;
        selIdx   = '0;
        cand     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(last) + 32'd1 + i) % N;
            if (!selValid && Req_clkA[IW'(cand)]) begin
                selValid = 1'b1;
                selIdx   = IW'(cand);
            end
        end
    end

    // Arbitration FSM with registered grant, start, done, command and watchdog
    always_ff @(posedge clkA) begin
        if (Reset_clkA) begin
            state          <= IDLE;
            last           <= IW'(N - 1);
            grantIdx       <= '0;
            Grant_clkA     <= '0;
            Done_clkA      <= '0;
            TaskStart_clkA <= 1'b0;
            TaskCmd_clkA   <= '0;
            Timeout_clkA   <= 1'b0;
            wdCnt          <= '0;
        end else begin
            Done_clkA <= '0;
            unique case (state)
                IDLE: begin
                    // TaskBusy gate covers a far side still finishing a task
                    // orphaned by a reset; its late TaskDone is ignored here.
                    if (selValid && !TaskBusy_clkA) begin
                        grantIdx       <= selIdx;
                        Grant_clkA     <= N'(1) << selIdx;
                        TaskCmd_clkA   <= Cmd_clkA[selIdx*W +: W];
                        TaskStart_clkA <= 1'b1;
                        state          <= START;
                    end
                end
                START: begin
                    TaskStart_clkA <= 1'b0;
                    wdCnt          <= '0;
                    state          <= WAIT;
                end
                WAIT: begin
                    if (wdCnt < CW'(TIMEOUT)) begin
                        wdCnt <= wdCnt + 1'b1;
                        if (wdCnt == CW'(TIMEOUT - 1)) begin
                            Timeout_clkA <= 1'b1;
                        end
                    end
                    if (TaskDone_clkA) begin
                        Done_clkA  <= Grant_clkA;
                        Grant_clkA <= '0;
                        last       <= grantIdx;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_domain_task_arbiter.sv
// Self-checking bench for domain_task_arbiter: a behavioural far-side
// domain_task model, a table of single-task transactions, and directed
// sequences for round-robin, back-to-back, watchdog and reset mid-task.
module tb_domain_task_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 16;

    logic           clkA = 1'b0;
    logic           Reset_clkA;
    logic [N-1:0]   Req_clkA;
    logic [N*W-1:0] Cmd_clkA;
    logic [N-1:0]   Grant_clkA;
    logic [N-1:0]   Done_clkA;
    logic           TaskStart_clkA;
    logic [W-1:0]   TaskCmd_clkA;
    logic           TaskBusy_clkA;
    logic           TaskDone_clkA;
    logic           Timeout_clkA;

    domain_task_arbiter #(.N(N), .W(W), .TIMEOUT(8)) dut (
        .clkA           (clkA),
        .Reset_clkA     (Reset_clkA),
        .Req_clkA       (Req_clkA),
        .Cmd_clkA       (Cmd_clkA),
        .Grant_clkA     (Grant_clkA),
        .Done_clkA      (Done_clkA),
        .TaskStart_clkA (TaskStart_clkA),
        .TaskCmd_clkA   (TaskCmd_clkA),
        .TaskBusy_clkA  (TaskBusy_clkA),
        .TaskDone_clkA  (TaskDone_clkA),
        .Timeout_clkA   (Timeout_clkA)
    );

    always #5 clkA = ~clkA;

    int cyc = 0;
    always @(posedge clkA) cyc <= cyc + 1;

    int passCnt = 0;
    int totalCnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clkA);
        #2;
    endtask

    // Far-side model: busy from the cycle after TaskStart for farLen cycles,
    // TaskDone in the last busy cycle. Unaffected by the arbiter's reset.
    int farLen = 5;
    initial begin
        TaskBusy_clkA = 1'b0;
        TaskDone_clkA = 1'b0;
        forever begin
            @(posedge clkA);
            if (TaskStart_clkA === 1'b1) begin
                #1;
                TaskBusy_clkA = 1'b1;
                repeat (farLen - 1) begin
                    @(posedge clkA);
                    #1;
                end
                TaskDone_clkA = 1'b1;
                @(posedge clkA);
                #1;
                TaskBusy_clkA = 1'b0;
                TaskDone_clkA = 1'b0;
            end
        end
    end

    // Monitor on the falling edge: counters, one-hot checks, throughput gap
    int startCnt = 0;
    int doneCnt = 0;
    int lastTdCyc = 0;
    int gapN = 0;
    bit gapCheck = 1'b0;
    bit tdSeen = 1'b0;
    initial begin
        forever begin
            @(negedge clkA);
            if (Reset_clkA === 1'b0) begin
                chk("grantOneHot", 32'($onehot0(Grant_clkA)), 32'd1);
                chk("doneOneHot", 32'($onehot0(Done_clkA)), 32'd1);
            end
            if (TaskStart_clkA === 1'b1) begin
                startCnt++;
                if (gapCheck && tdSeen) begin
                    chk("b2bGap", 32'(cyc - lastTdCyc), 32'd2);
                    gapN++;
                end
            end
            if (Done_clkA !== '0) doneCnt++;
            if (TaskDone_clkA === 1'b1) begin
                lastTdCyc = cyc;
                if (gapCheck) tdSeen = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL globalTimeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [N-1:0] req;
        logic [W-1:0] cmdBase;
        logic [N-1:0] expGrant;
        logic [W-1:0] expCmd;
    } vecT;

    vecT vecs[9];

    task automatic doReset();
        Reset_clkA = 1'b1;
        step();
        step();
        Reset_clkA = 1'b0;
    endtask

    task automatic waitDone();
        for (int n = 0; n < 100; n++) begin
            step();
            if (Done_clkA !== '0) return;
        end
    endtask

    // One full transaction: request, check selection, withdraw, await Done
    task automatic runVec(input vecT v);
        int s0;
        s0 = startCnt;
        Req_clkA = v.req;
        for (int i = 0; i < N; i++) Cmd_clkA[i*W +: W] = v.cmdBase + 16'(i);
        step();
        chk("vecGrant", 32'(Grant_clkA), 32'(v.expGrant));
        chk("vecCmd", 32'(TaskCmd_clkA), 32'(v.expCmd));
        chk("vecStart", 32'(TaskStart_clkA), 32'd1);
        step();
        Req_clkA = '0;
        chk("vecStartOneCycle", 32'(TaskStart_clkA), 32'd0);
        waitDone();
        chk("vecDone", 32'(Done_clkA), 32'(v.expGrant));
        chk("vecGrantCleared", 32'(Grant_clkA), 32'd0);
        chk("vecOneStart", 32'(startCnt - s0), 32'd1);
        step();
        chk("vecDonePulse", 32'(Done_clkA), 32'd0);
        chk("vecCmdHeld", 32'(TaskCmd_clkA), 32'(v.expCmd));
        step();
        chk("vecNoRegrant", 32'(Grant_clkA), 32'd0);
    endtask

    initial begin
        logic [N-1:0] rrExp[5];
        int s0;
        int d0;
        int n;

        vecs[0] = '{4'b0100, 16'hA5C1, 4'b0100, 16'hA5C3};
        vecs[1] = '{4'b0101, 16'h1000, 4'b0001, 16'h1000};
        vecs[2] = '{4'b1111, 16'h2000, 4'b0010, 16'h2001};
        vecs[3] = '{4'b0010, 16'h3000, 4'b0010, 16'h3001};
        vecs[4] = '{4'b1001, 16'h4000, 4'b1000, 16'h4003};
        vecs[5] = '{4'b1010, 16'h5000, 4'b0010, 16'h5001};
        vecs[6] = '{4'b0001, 16'h6000, 4'b0001, 16'h6000};
        vecs[7] = '{4'b1000, 16'hFFF0, 4'b1000, 16'hFFF3};
        vecs[8] = '{4'b0110, 16'h7000, 4'b0010, 16'h7001};
        rrExp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        Reset_clkA = 1'b1;
        Req_clkA   = '0;
        Cmd_clkA   = '0;
        step();
        step();
        chk("rstGrant", 32'(Grant_clkA), 32'd0);
        chk("rstDone", 32'(Done_clkA), 32'd0);
        chk("rstStart", 32'(TaskStart_clkA), 32'd0);
        chk("rstCmd", 32'(TaskCmd_clkA), 32'd0);
        chk("rstTimeout", 32'(Timeout_clkA), 32'd0);
        Reset_clkA = 1'b0;
        step();

        // Table of transactions, far side 5 cycles busy (below watchdog bound)
        farLen = 5;
        for (int i = 0; i < 9; i++) runVec(vecs[i]);
        chk("tableNoTimeout", 32'(Timeout_clkA), 32'd0);

        // Round-robin with all requests held
        doReset();
        farLen = 3;
        s0 = startCnt;
        d0 = doneCnt;
        Req_clkA = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 50; k++) begin
                step();
                if (TaskStart_clkA === 1'b1) break;
            end
            chk("rrGrant", 32'(Grant_clkA), 32'(rrExp[g]));
        end
        Req_clkA = '0;
        repeat (20) step();
        chk("rrStarts", 32'(startCnt - s0), 32'd5);
        chk("rrDones", 32'(doneCnt - d0), 32'd5);

        // Back-to-back throughput with a one-cycle far side
        doReset();
        farLen = 1;
        tdSeen = 1'b0;
        gapN = 0;
        gapCheck = 1'b1;
        Req_clkA = 4'b0011;
        n = 0;
        for (int k = 0; k < 60 && n < 3; k++) begin
            step();
            if (TaskStart_clkA === 1'b1) n++;
        end
        Req_clkA = '0;
        step();
        gapCheck = 1'b0;
        chk("b2bGapCount", 32'(gapN), 32'd2);
        repeat (10) step();

        // Watchdog: 7 WAIT cycles stays clear, 12 WAIT cycles trips it
        doReset();
        farLen = 7;
        Req_clkA = 4'b0001;
        step();
        Req_clkA = '0;
        waitDone();
        chk("wdShortDone", 32'(Done_clkA), 32'd1);
        chk("wdShortNoTimeout", 32'(Timeout_clkA), 32'd0);
        repeat (3) step();
        farLen = 12;
        Req_clkA = 4'b0001;
        step();
        chk("wdStart", 32'(TaskStart_clkA), 32'd1);
        Req_clkA = '0;
        repeat (8) step();
        chk("wdBefore", 32'(Timeout_clkA), 32'd0);
        step();
        chk("wdRise", 32'(Timeout_clkA), 32'd1);
        waitDone();
        chk("wdLongDone", 32'(Done_clkA), 32'd1);
        repeat (3) step();
        chk("wdSticky", 32'(Timeout_clkA), 32'd1);
        doReset();
        chk("wdResetClears", 32'(Timeout_clkA), 32'd0);
        repeat (3) step();

        // Reset while the far side is still busy, request held throughout
        farLen = 10;
        Req_clkA = 4'b0001;
        step();
        chk("rmtStart", 32'(TaskStart_clkA), 32'd1);
        step();
        step();
        Reset_clkA = 1'b1;
        step();
        chk("rmtGrant", 32'(Grant_clkA), 32'd0);
        chk("rmtCmd", 32'(TaskCmd_clkA), 32'd0);
        chk("rmtStartLow", 32'(TaskStart_clkA), 32'd0);
        Reset_clkA = 1'b0;
        d0 = doneCnt;
        for (int k = 0; k < 40; k++) begin
            step();
            if (TaskStart_clkA === 1'b1) break;
        end
        chk("rmtRestart", 32'(TaskStart_clkA), 32'd1);
        chk("rmtRestartGap", 32'(cyc - lastTdCyc), 32'd2);
        chk("rmtNoStaleDone", 32'(doneCnt - d0), 32'd0);
        chk("rmtRegrant", 32'(Grant_clkA), 32'd1);
        Req_clkA = '0;
        waitDone();
        chk("rmtDone", 32'(Done_clkA), 32'd1);
        repeat (3) step();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/domain_task_arbiter.md
# domain_task_arbiter

Round-robin arbiter that shares one clkA-side `domain_task` crossing channel among N requesters in the clkA domain. It picks one requester, latches that requester's command word, and issues a single-cycle TaskStart. It holds the grant until the far domain reports completion, then returns a per-requester Done pulse. A watchdog flags tasks that stay outstanding longer than a programmable bound.

## Interface
- `N`, default 4: number of requesters (2..16).
- `W`, default 16: command word width per requester.
- `TIMEOUT`, default 1024: WAIT-state cycle count at which `Timeout_clkA` is set. The counter width is clog2(TIMEOUT+1).

Ports (clock and reset first):
- `clkA`, input, 1: sole clock; all logic is on its rising edge.
- `Reset_clkA`, input, 1: synchronous, active-high reset.
- `Req_clkA`, input, N: per-requester request level; sampled only in IDLE.
- `Cmd_clkA`, input, N*W: per-requester command words; requester i occupies bits [i*W+W-1 : i*W].
- `Grant_clkA`, output, N: one-hot; held from selection until completion.
- `Done_clkA`, output, N: one-cycle completion pulse to the granted requester.
- `TaskStart_clkA`, output, 1: connects to `domain_task` TaskStart_clkA.
- `TaskCmd_clkA`, output, W: latched command, stable while Grant is nonzero.
- `TaskBusy_clkA`, input, 1: from `domain_task`.
- `TaskDone_clkA`, input, 1: from `domain_task`.
- `Timeout_clkA`, output, 1: sticky watchdog flag.

## Operation
States:
- **IDLE**
  - If Req_clkA is nonzero and TaskBusy_clkA is 0, select the first requesting index searching upward from `last+1` (mod N).
  - Register Grant (one-hot), register TaskCmd from Cmd_clkA of the selected index, set TaskStart, go to START.
  - TaskDone_clkA is ignored in IDLE.
- **START**
  - TaskStart_clkA is high for exactly this one cycle, then go to WAIT.
  - Clear the watchdog counter.
- **WAIT**
  - The watchdog counter increments each cycle and saturates at TIMEOUT. Reaching TIMEOUT sets Timeout_clkA.
  - On TaskDone_clkA = 1:
    - register Done_clkA[idx] = 1 for one cycle;
    - clear Grant;
    - set `last` = idx;
    - go to IDLE.
  - A timeout does not abort the task. The arbiter keeps waiting for TaskDone.

Rules:
- Round-robin pointer `last` resets to N-1, so requester 0 wins the first contention.
- A requester that just completed has lowest priority in the next selection.
- Req changes after selection (drop or re-assert) have no effect on the in-flight task. Done still pulses for the granted index.
- TaskCmd_clkA holds its value after completion until the next selection. It is 0 only from reset.
- At most one Grant bit and at most one Done bit are high in any cycle.
- Timeout_clkA clears only on Reset_clkA.

Reset values:
- state IDLE, `last` = N-1.
- Grant_clkA = 0, Done_clkA = 0, TaskStart_clkA = 0, TaskCmd_clkA = 0, Timeout_clkA = 0, watchdog counter = 0.

## Timing
- A request sampled at edge 0 (IDLE) gives Grant, TaskCmd and TaskStart valid in cycle 1.
- `domain_task` samples TaskStart at edge 1, and TaskBusy_clkA rises in cycle 2.
- TaskDone_clkA pulses in the last cycle of TaskBusy, cycle k. Then:
  - Done_clkA and IDLE occur in cycle k+1, with Grant already 0;
  - TaskBusy is low in cycle k+1;
  - a pending request is selected at edge k+1, and the next TaskStart appears in cycle k+2.
- Minimum gap between TaskStarts is therefore 2 cycles after the task's TaskDone cycle.
- Reset mid-task:
  - Outputs clear on the next edge, but `domain_task` may still be busy.
  - IDLE waits for TaskBusy_clkA = 0 before any new selection.
  - A stale TaskDone pulse arriving in IDLE is discarded and produces no Done_clkA.
- Simultaneous TaskDone and new Req in the same WAIT cycle: completion is processed first. The new Req is evaluated in IDLE the following cycle.

## Test plan
- **Single request.** Reset, then Req=4'b0100 with Cmd[2]=16'hA5C3, and far side done after 10 clkB cycles.
  - Grant=4'b0100 and TaskCmd=16'hA5C3 in cycle 1.
  - One TaskStart pulse.
  - One Done_clkA=4'b0100 pulse.
  - Grant=0 afterwards.
- **Round-robin.** Req=4'b1111 held continuously.
  - Grants occur in order 0,1,2,3,0.
  - Exactly one TaskStart per grant.
  - No overlapping Grant bits.
- **Request withdrawn.** Req[1] asserted then dropped in cycle 2.
  - The task still completes.
  - Done_clkA[1] pulses once.
  - No new grant until another Req appears.
- **Watchdog.** TIMEOUT=8, far side delays TaskDone beyond 8 WAIT cycles.
  - Timeout_clkA rises after the 8th WAIT cycle and stays high after Done.
  - Only Reset_clkA clears it.
- **Reset mid-task.** Assert Reset_clkA during WAIT while `domain_task` is busy, with Req=4'b0001 held.
  - Outputs go to 0.
  - The stale TaskDone produces no Done_clkA.
  - The next TaskStart occurs only after TaskBusy_clkA=0.
- **Back-to-back throughput.** Req=4'b0011 held, with fast clkB.
  - The second TaskStart occurs exactly 2 cycles after the first task's TaskDone_clkA cycle.
